// File: rtl/dmx_pkg.sv
// Shared DMX512 definitions: transmitter line states and slot framing constants.
package dmx_pkg;

    localparam int unsigned BITS_PER_SLOT = 11;
    localparam int unsigned STOP_BITS     = 2;
    localparam int unsigned DATA_BITS     = BITS_PER_SLOT - 1 - STOP_BITS;
    localparam logic [7:0]  START_CODE    = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        MAB,
        START,
        DATA,
        STOP
    } dmx_state_e;

endpackage

// File: rtl/dmx_baud_tick.sv
// Free-running bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
module dmx_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 108
) (
    input  logic clk,
    input  logic reset,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || tick_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick_c = (count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/dmx_frame_tx.sv
// DMX512 frame transmitter: break, MAB, start code and NUM_SLOTS 8N2 slots fetched on demand.
// Optional frame counter output enabled by defining DMX_FRAME_CNT_EN.
module dmx_frame_tx
    import dmx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 108,
    parameter int unsigned NUM_SLOTS    = 512,
    parameter int unsigned BREAK_BITS   = 25,
    parameter int unsigned MAB_BITS     = 2,
    parameter int unsigned DATA_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [8:0]  request_addr,
    output logic        request_pulse,
    input  logic [7:0]  data_in,
    output logic        dmx_out,
    output logic        frame_start,
    output logic        busy
`ifdef DMX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned MAX_BITS = (BREAK_BITS > MAB_BITS)
                                     ? ((BREAK_BITS > DATA_BITS) ? BREAK_BITS : DATA_BITS)
                                     : ((MAB_BITS > DATA_BITS) ? MAB_BITS : DATA_BITS);
    localparam int unsigned BIT_W    = $clog2(MAX_BITS + 1);
    localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS + 1);
    localparam int unsigned MARK_W   = $clog2(CLKS_PER_BIT + 1);

    dmx_state_e        state, state_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [SLOT_W-1:0] slot_idx, slot_d;
    logic [7:0]        shreg, shreg_d;
    logic [MARK_W-1:0] mark_cnt;
    logic [8:0]        addr_d;
    logic              pulse_d, dmx_d, frame_start_d, busy_d;
    logic              tick_c, capture_c, mark_done_c;

    dmx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .tick_c(tick_c)
    );

    // Delay the request strobe so the slot value is sampled exactly DATA_LATENCY cycles later.
    generate
        if (DATA_LATENCY == 0) begin : g_lat0
            assign capture_c = request_pulse;
        end else begin : g_latn
            logic [DATA_LATENCY-1:0] lat_pipe;
            always_ff @(posedge clk) begin
                if (reset) begin
                    lat_pipe <= '0;
                end else begin
                    lat_pipe <= (lat_pipe << 1) | DATA_LATENCY'(request_pulse);
                end
            end
            assign capture_c = lat_pipe[DATA_LATENCY-1];
        end
    endgenerate

    // IDLE mark timer: a break may only follow at least one full bit of mark.
    always_ff @(posedge clk) begin
        if (reset || (state != IDLE)) begin
            mark_cnt <= '0;
        end else if (mark_cnt != MARK_W'(CLKS_PER_BIT)) begin
            mark_cnt <= mark_cnt + MARK_W'(1);
        end
    end

    assign mark_done_c = (mark_cnt >= MARK_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            slot_idx      <= '0;
            shreg         <= '0;
            dmx_out       <= 1'b1;
            request_pulse <= 1'b0;
            request_addr  <= '0;
            frame_start   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            bit_cnt       <= bit_cnt_d;
            slot_idx      <= slot_d;
            shreg         <= shreg_d;
            dmx_out       <= dmx_d;
            request_pulse <= pulse_d;
            request_addr  <= addr_d;
            frame_start   <= frame_start_d;
            busy          <= busy_d;
        end
    end

    // Next state and next registered outputs; all transitions land on a divider wrap.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        slot_d    = slot_idx;
        shreg_d   = shreg;
        pulse_d   = 1'b0;
        addr_d    = request_addr;

        if (capture_c) begin
            shreg_d = data_in;
        end

        if (tick_c) begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
            case (state)
                IDLE: begin
                    bit_cnt_d = '0;
                    if (enable && mark_done_c) begin
                        state_d = BREAK;
                    end
                end
                BREAK: begin
                    if (bit_cnt == BIT_W'(BREAK_BITS - 1)) begin
                        state_d   = MAB;
                        bit_cnt_d = '0;
                    end
                end
                MAB: begin
                    if (bit_cnt == BIT_W'(MAB_BITS - 1)) begin
                        state_d   = START;
                        bit_cnt_d = '0;
                        slot_d    = '0;
                        shreg_d   = START_CODE;
                    end
                end
                START: begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shreg_d = shreg_d >> 1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (slot_idx == SLOT_W'(NUM_SLOTS)) begin
                            state_d = IDLE;
                        end else begin
                            state_d = START;
                            slot_d  = slot_idx + SLOT_W'(1);
                            pulse_d = 1'b1;
                            addr_d  = 9'(slot_idx);
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end

        frame_start_d = (state == IDLE) && (state_d == BREAK);
        busy_d        = (state_d != IDLE);

        case (state_d)
            BREAK, START: dmx_d = 1'b0;
            DATA:         dmx_d = shreg_d[0];
            default:      dmx_d = 1'b1;
        endcase
    end

`ifdef DMX_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmx_frame_tx.sv
// Bench for dmx_frame_tx: frame-offset reference model checked every cycle plus literal pins.
module tb_dmx_frame_tx;

    localparam int CPB       = 4;
    localparam int NSL       = 3;
    localparam int BRK       = 25;
    localparam int MABB      = 2;
    localparam int LAT       = 2;
    localparam int SLOT_BITS = 11;
    localparam int FRAME_CYC = (BRK + MABB + SLOT_BITS * (NSL + 1)) * CPB;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [8:0] request_addr;
    logic       request_pulse;
    logic [7:0] data_in;
    logic       dmx_out;
    logic       frame_start;
    logic       busy;
`ifdef DMX_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    dmx_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_SLOTS   (NSL),
        .BREAK_BITS  (BRK),
        .MAB_BITS    (MABB),
        .DATA_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .request_addr (request_addr),
        .request_pulse(request_pulse),
        .data_in      (data_in),
        .dmx_out      (dmx_out),
        .frame_start  (frame_start),
        .busy         (busy)
`ifdef DMX_FRAME_CNT_EN
        ,
        .frame_count  (frame_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit force_a5 = 1'b0;

    // Reference model: position within the current frame, or mark time while idle.
    bit         m_valid    = 1'b0;
    bit         m_in_frame = 1'b0;
    int         m_off      = 0;
    int         m_mark     = 0;
    int         m_addr     = 0;
    logic [7:0] slot_val [0:NSL];

    logic wave [0:FRAME_CYC + 4];
    logic pls  [0:FRAME_CYC + 4];
    logic bsy  [0:FRAME_CYC + 4];
    logic fsv  [0:FRAME_CYC + 4];
    int   adr  [0:FRAME_CYC + 4];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic model_compare();
        logic e_dmx, e_busy, e_fs, e_req;
        int b, ph, s, j;
        if (m_valid) begin
            e_dmx = 1'b1; e_busy = 1'b0; e_fs = 1'b0; e_req = 1'b0;
            if (m_in_frame) begin
                b = m_off / CPB;
                ph = m_off % CPB;
                e_busy = 1'b1;
                e_fs = (m_off == 0);
                if (b < BRK) begin
                    e_dmx = 1'b0;
                end else if (b < BRK + MABB) begin
                    e_dmx = 1'b1;
                end else begin
                    s = (b - BRK - MABB) / SLOT_BITS;
                    j = (b - BRK - MABB) % SLOT_BITS;
                    if (j == 0) begin
                        e_dmx = 1'b0;
                        if (s >= 1 && ph == 0) begin
                            e_req = 1'b1;
                            m_addr = s - 1;
                        end
                    end else if (j <= 8) begin
                        e_dmx = slot_val[s][j-1];
                    end else begin
                        e_dmx = 1'b1;
                    end
                end
            end
            checks++;
            if (dmx_out !== e_dmx || busy !== e_busy || frame_start !== e_fs ||
                request_pulse !== e_req || request_addr !== 9'(m_addr)) begin
                errors++;
                $display("FAIL cycle %0d outputs: got dmx=%b busy=%b fs=%b req=%b addr=%0d, want dmx=%b busy=%b fs=%b req=%b addr=%0d",
                         cyc, dmx_out, busy, frame_start, request_pulse, request_addr,
                         e_dmx, e_busy, e_fs, e_req, m_addr);
            end
        end
    endtask

    // Advance the model by one cycle using the inputs the DUT will sample at the next edge.
    task automatic model_advance();
        int b, ph, s, j;
        if (reset === 1'b1) begin
            m_valid = 1'b1;
            m_in_frame = 1'b0;
            m_mark = 0;
            m_addr = 0;
        end else if (m_valid) begin
            if (m_in_frame) begin
                b = m_off / CPB;
                ph = m_off % CPB;
                if (b >= BRK + MABB) begin
                    s = (b - BRK - MABB) / SLOT_BITS;
                    j = (b - BRK - MABB) % SLOT_BITS;
                    if (s >= 1 && j == 0 && ph == LAT) slot_val[s] = data_in;
                end
                if (m_off == FRAME_CYC - 1) begin
                    m_in_frame = 1'b0;
                    m_mark = 0;
                end else begin
                    m_off++;
                end
            end else begin
                if ((m_mark % CPB) == CPB - 1 && enable === 1'b1) begin
                    m_in_frame = 1'b1;
                    m_off = 0;
                    slot_val[0] = 8'h00;
                end
                m_mark++;
            end
        end
    endtask

    task automatic cycle();
        data_in = force_a5 ? 8'hA5 : 8'($urandom);
        model_advance();
        @(negedge clk);
        cyc++;
        model_compare();
    endtask

    int n;
    int cur;
    int fs_cnt;
    int bad_line;
    int run_len[$];
    int p_idx[$];
    int p_addr[$];
    int exp_runs[12] = '{100, 8, 36, 8, 4, 4, 4, 4, 8, 4, 4, 12};

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        data_in = 8'h00;
        #1;
        repeat (3) cycle();

        // Directed frame with every slot reading 0xA5.
        force_a5 = 1'b1;
        reset = 1'b0;
        enable = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (frame_start !== 1'b1 && n < 400);
        chk("first_break_delay", n, 4);

        wave[0] = dmx_out; pls[0] = request_pulse; bsy[0] = busy;
        fsv[0] = frame_start; adr[0] = int'(request_addr);
        for (int i = 1; i <= FRAME_CYC + 4; i++) begin
            cycle();
            wave[i] = dmx_out; pls[i] = request_pulse; bsy[i] = busy;
            fsv[i] = frame_start; adr[i] = int'(request_addr);
        end
        force_a5 = 1'b0;

        chk("break_level", int'(wave[0] === 1'b1), 0);
        cur = 1;
        for (int i = 1; i <= FRAME_CYC + 4; i++) begin
            if (wave[i] === wave[i-1]) cur++;
            else begin run_len.push_back(cur); cur = 1; end
        end
        for (int k = 0; k < 12; k++)
            chk($sformatf("run_len[%0d]", k), (k < run_len.size()) ? run_len[k] : -1, exp_runs[k]);

        for (int i = 0; i < FRAME_CYC + 4; i++)
            if (pls[i] === 1'b1) begin p_idx.push_back(i); p_addr.push_back(adr[i]); end
        chk("request_count", p_idx.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("request_cycle[%0d]", k), (k < p_idx.size()) ? p_idx[k] : -1, 152 + 44 * k);
            chk($sformatf("request_addr[%0d]", k), (k < p_addr.size()) ? p_addr[k] : -1, k);
        end
        chk("busy_last_stop", int'(bsy[FRAME_CYC - 1] === 1'b1), 1);
        chk("busy_after_frame", int'(bsy[FRAME_CYC] === 1'b1), 0);
        chk("frame_period_a5", int'(fsv[FRAME_CYC + 4] === 1'b1), 1);

        // Back-to-back frame with random slot data.
        n = 0;
        do begin cycle(); n++; end while (frame_start !== 1'b1 && n < 1000);
        chk("frame_period_random", n, 288);

        // Drop enable in the middle of the second data slot.
        n = 0;
        do begin cycle(); n++; end
        while (!(request_pulse === 1'b1 && request_addr === 9'd1) && n < 1000);
        chk("slot2_request_seen", int'(n < 1000), 1);
        repeat (20) cycle();
        enable = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (busy !== 1'b0 && n < 1000);
        chk("drain_cycles", n, 68);
        fs_cnt = 0;
        bad_line = 0;
        repeat (300) begin
            cycle();
            if (frame_start === 1'b1) fs_cnt++;
            if (dmx_out !== 1'b1 || busy !== 1'b0) bad_line++;
        end
        chk("quiet_frame_starts", fs_cnt, 0);
        chk("quiet_line_not_mark", bad_line, 0);

        // Reset in the data bits of the first data slot.
        enable = 1'b1;
        n = 0;
        do begin cycle(); n++; end
        while (!(request_pulse === 1'b1 && request_addr === 9'd0) && n < 1000);
        chk("slot1_request_seen", int'(n < 1000), 1);
        repeat (6) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("reset_dmx_mark", int'(dmx_out === 1'b1), 1);
        chk("reset_no_request", int'(request_pulse === 1'b1), 0);
        chk("reset_not_busy", int'(busy === 1'b1), 0);
        n = 0;
        do begin cycle(); n++; end while (frame_start !== 1'b1 && n < 400);
        chk("break_after_reset", n, 4);

        // Random enable toggles and occasional resets, checked by the model every cycle.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            reset = ($urandom_range(0, 1999) == 0);
            cycle();
        end
        reset = 1'b0;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmx_frame_tx.md
DMX_FRAME_TX -- requirements
Module: dmx_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 108, clk cycles per 4 us DMX bit (27 MHz / 250 kbaud).
REQ-002 Parameter NUM_SLOTS, default 512, data slots per frame after the start code; legal range 1..512.
REQ-003 Parameter BREAK_BITS, default 25, break length in bit times (100 us).
REQ-004 Parameter MAB_BITS, default 2, mark-after-break length in bit times (8 us).
REQ-005 Parameter DATA_LATENCY, default 2, cycles from request_pulse to valid data_in; must be less than CLKS_PER_BIT.
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  high = transmit frames back to back; low = hold the line at mark after the current frame.
REQ-009 request_addr  output  9  0-based slot index being fetched (slot 0 = DMX channel 1).
REQ-010 request_pulse  output  1  one-cycle strobe; request_addr is valid in the same cycle.
REQ-011 data_in  input  8  slot value from the upstream processor, valid DATA_LATENCY cycles after request_pulse.
REQ-012 dmx_out  output  1  serial DMX line toward the RS-485 driver; 1 = mark.
REQ-013 frame_start  output  1  one-cycle pulse in the first cycle of the break.
REQ-014 busy  output  1  high from break start through the last stop bit.

Function
REQ-015 States SHALL be IDLE, BREAK, MAB, START, DATA, STOP.
REQ-016 Bit timing SHALL come from a divider that counts 0..CLKS_PER_BIT-1; every state change happens on a divider wrap.
REQ-017 IDLE: dmx_out=1; after at least 1 full bit of mark, with enable=1, the next cycle SHALL enter BREAK.
REQ-018 BREAK: dmx_out=0 for BREAK_BITS*CLKS_PER_BIT cycles, then MAB.
REQ-019 MAB: dmx_out=1 for MAB_BITS*CLKS_PER_BIT cycles, then START of slot "start code".
REQ-020 Every slot SHALL be 8N2: 1 start bit (0), 8 data bits LSB first, 2 stop bits (1); 11 bits per slot.
REQ-021 The start-code slot SHALL send 0x00 and SHALL NOT issue a request.
REQ-022 For data slot k (0..NUM_SLOTS-1), request_pulse=1 and request_addr=k SHALL occur in the first cycle of that slot's start bit.
REQ-023 data_in SHALL be latched exactly DATA_LATENCY cycles after the pulse, into a shift register; data bits are taken from this register only.
REQ-024 After the stop bits of slot NUM_SLOTS-1, the block SHALL go to IDLE; there are no inter-slot mark gaps.
REQ-025 enable is sampled only in IDLE; deasserting it mid-frame SHALL NOT truncate the frame.
REQ-026 Frame length SHALL be (BREAK_BITS + MAB_BITS + 11*(NUM_SLOTS+1) + 1)*CLKS_PER_BIT cycles when enable is held high.
REQ-027 request_addr SHALL hold its last value between pulses.

Reset
REQ-028 While reset is high, the next edge SHALL set: state=IDLE, dmx_out=1, request_pulse=0, request_addr=0, frame_start=0, busy=0, divider=0, and the IDLE mark timer=0.
REQ-029 Reset mid-frame SHALL abandon the frame; the line stays at mark for at least 1 bit before a full new break.

Configuration
REQ-030 With DMX_FRAME_CNT_EN defined: output frame_count[15:0] SHALL increment, wrapping, on each frame_start and reset to 0.
REQ-031 Without DMX_FRAME_CNT_EN: no frame_count port and no counter logic.

Structure
REQ-032 The state enum, the 0x00 start-code constant, and the bits-per-slot constant (11) SHALL live in shared package dmx_pkg.
REQ-033 The bit-tick divider SHALL be sub-module dmx_baud_tick, reusable by other DMX blocks.

Verification (CLKS_PER_BIT=4, NUM_SLOTS=3, DATA_LATENCY=2)
REQ-034 Reset then enable=1 -> after 4 cycles of mark, frame_start; dmx_out low for 100 cycles, high for 8 cycles, busy=1.
REQ-035 Start code -> 4 cycles low + 32 cycles low + 8 cycles high; no request_pulse.
REQ-036 data_in=0xA5 for addr 0 -> request_pulse with addr=0 on the first start-bit cycle of slot 1; data bits 1,0,1,0,0,1,0,1, each 4 cycles.
REQ-037 enable held high -> frame_start period = 288 cycles; request_addr sequence 0,1,2 per frame.
REQ-038 enable dropped in the middle of slot 2 -> frame completes, then dmx_out=1 and busy=0 indefinitely.
REQ-039 reset asserted in DATA of slot 1 -> next cycle dmx_out=1, request_pulse=0; new break starts after at least 4 mark cycles.
